// File: rtl/ysyx_25020047_lsu.sv
// Load/store unit: one handshaked word-port access per request, with
// misalignment/conflict detection and a REQ+WAIT timeout.
module ysyx_25020047_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        read,
    input  logic        write,
    input  logic        word,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES - 1);

    state_t      state, state_d;
    logic [8:0]  cnt, cnt_d;
    logic [1:0]  off_q;
    logic        word_q, write_q;
    logic [31:0] rdata_d;
    logic        err_d;
    logic        go_mem;
    logic [7:0]  rd_byte;

    assign req_ready     = (state == IDLE);
    assign resp_valid    = (state == DONE);
    assign mem_req_valid = (state == REQ);
    assign rd_byte       = mem_rdata[{off_q, 3'b000} +: 8];

    // resp_rdata/resp_err are loaded only on the edge entering DONE, so they
    // fall back to zero automatically on the edge leaving it.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rdata_d = '0;
        err_d   = 1'b0;
        go_mem  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!read && !write) begin
                        state_d = DONE;
                    end else if ((read && write) || (word && addr[1:0] != 2'b00)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                        go_mem  = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt + 9'd1;
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (cnt >= LIMIT) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt + 9'd1;
                if (mem_rsp_valid) begin
                    state_d = DONE;
                    if (!write_q) begin
                        rdata_d = word_q ? mem_rdata : {24'b0, rd_byte};
                    end
                end else if (cnt >= LIMIT) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_wen    <= 1'b0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            off_q      <= '0;
            word_q     <= 1'b0;
            write_q    <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
            if (go_mem) begin
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wen   <= write;
                mem_wdata <= word ? wdata : {4{wdata[7:0]}};
                mem_wstrb <= !write ? 4'b0000 : (word ? 4'b1111 : (4'b0001 << addr[1:0]));
                off_q     <= addr[1:0];
                word_q    <= word;
                write_q   <= write;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Self-checking bench: two LSU instances (default timeout and TIMEOUT_CYCLES=4)
// checked against a behavioural access/latency model.
module tb_ysyx_25020047_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic [31:0] addr, wdata, mem_rdata;
    logic        read, write, word;
    logic        mem_req_ready, mem_rsp_valid;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req_valid, a_mem_wen;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wstrb;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req_valid, b_mem_wen;
    logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_wstrb;

    logic        sel;
    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_req_valid, o_mem_wen;
    logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_25020047_lsu dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(a_req_ready),
        .addr(addr), .wdata(wdata), .read(read), .write(write), .word(word),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(a_mem_addr), .mem_wen(a_mem_wen), .mem_wdata(a_mem_wdata),
        .mem_wstrb(a_mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    ysyx_25020047_lsu #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(b_req_ready),
        .addr(addr), .wdata(wdata), .read(read), .write(write), .word(word),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(b_mem_addr), .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata),
        .mem_wstrb(b_mem_wstrb), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
    );

    assign o_req_ready     = sel ? b_req_ready     : a_req_ready;
    assign o_resp_valid    = sel ? b_resp_valid    : a_resp_valid;
    assign o_resp_err      = sel ? b_resp_err      : a_resp_err;
    assign o_resp_rdata    = sel ? b_resp_rdata    : a_resp_rdata;
    assign o_mem_req_valid = sel ? b_mem_req_valid : a_mem_req_valid;
    assign o_mem_addr      = sel ? b_mem_addr      : a_mem_addr;
    assign o_mem_wen       = sel ? b_mem_wen       : a_mem_wen;
    assign o_mem_wdata     = sel ? b_mem_wdata     : a_mem_wdata;
    assign o_mem_wstrb     = sel ? b_mem_wstrb     : a_mem_wstrb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Expected result of one access from its request fields alone.
    task automatic model(input logic [31:0] a, input logic [31:0] wd, input bit rd, input bit wr,
                         input bit wo, input logic [31:0] mrd, output bit mem, output bit err,
                         output logic [31:0] rdata, output logic [3:0] strb, output logic [31:0] mwd);
        int sh;
        sh    = 8 * int'(a % 4);
        err   = (rd || wr) && ((rd && wr) || (wo && (a % 4) != 0));
        mem   = (rd || wr) && !err;
        rdata = 0;
        if (mem && rd) rdata = wo ? mrd : ((mrd >> sh) & 32'hFF);
        strb  = !(mem && wr) ? 4'd0 : (wo ? 4'd15 : 4'(1 << (a % 4)));
        mwd   = wo ? wd : (wd & 32'hFF) * 32'h01010101;
    endtask

    task automatic run(input bit s, input logic [31:0] a, input logic [31:0] wd, input bit rd,
                       input bit wr, input bit wo, input int rdly, input int sdly,
                       input logic [31:0] mrd);
        bit mem, err, to;
        logic [31:0] rdata, mwd, exp_rdata;
        logic [3:0] strb;
        int t, exp_lat, lat, c, rsp_c;
        t = s ? 4 : 64;
        model(a, wd, rd, wr, wo, mrd, mem, err, rdata, strb, mwd);
        rsp_c = rdly + 1 + sdly;
        to = mem && (rdly > t - 1 || rsp_c > t - 1);
        exp_lat = !mem ? 1 : (to ? t + 1 : rdly + sdly + 3);
        exp_rdata = to ? 32'd0 : rdata;

        @(negedge clk);
        sel = s;
        chk("idle_req_ready", o_req_ready, 1);
        addr = a; wdata = wd; read = rd; write = wr; word = wo;
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        @(posedge clk);
        #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        addr = $urandom; wdata = $urandom; read = $urandom; write = $urandom; word = $urandom;

        lat = 0;
        for (int k = 1; k <= t + 6; k++) begin
            @(negedge clk);
            if (o_resp_valid) begin
                lat = k;
                break;
            end
            c = k - 1;
            chk("busy_req_ready", o_req_ready, 0);
            if (c <= rdly) begin
                chk("req_valid", o_mem_req_valid, 1);
                chk("mem_addr", o_mem_addr, {a[31:2], 2'b00});
                chk("mem_wen", o_mem_wen, wr);
                chk("mem_wstrb", o_mem_wstrb, strb);
                if (wr) chk("mem_wdata", o_mem_wdata, mwd);
                mem_req_ready = (c == rdly);
                mem_rsp_valid = 1'b0;
            end else begin
                chk("wait_no_req", o_mem_req_valid, 0);
                mem_req_ready = 1'b0;
                mem_rsp_valid = (c == rsp_c);
                mem_rdata = (c == rsp_c) ? mrd : $urandom;
            end
        end
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("resp_err", o_resp_err, err || to);
        chk("resp_rdata", o_resp_rdata, exp_rdata);
        chk("done_no_req", o_mem_req_valid, 0);
        @(negedge clk);
        chk("pulse_end", o_resp_valid, 0);
        chk("rdata_cleared", o_resp_rdata, 0);
        chk("err_cleared", o_resp_err, 0);
        chk("back_idle", o_req_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        addr = '0; wdata = '0; read = 1'b0; write = 1'b0; word = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        req_valid_a = 1'b1; read = 1'b1; word = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", o_req_ready, 1);
        chk("rst_resp_valid", o_resp_valid, 0);
        chk("rst_mem_req_valid", o_mem_req_valid, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_mem_wstrb", o_mem_wstrb, 0);
        chk("rst_resp_rdata", o_resp_rdata, 0);
        req_valid_a = 1'b0;
        rst_n = 1'b1;

        // word load, minimum latency
        run(0, 32'h80000010, 32'h0, 1, 0, 1, 0, 0, 32'hDEADBEEF);
        // byte load / byte store sweep
        for (int i = 0; i < 4; i++) begin
            run(0, 32'h80000100 + i, 32'h0, 1, 0, 0, 0, 1, 32'h44332211);
            run(0, 32'h80000200 + i, 32'h000000A5, 0, 1, 0, 1, 0, 32'h0);
        end
        // misaligned, conflict, no-op
        run(0, 32'h80000002, 32'h0, 1, 0, 1, 0, 0, 32'h0);
        run(0, 32'h80000004, 32'h0, 1, 1, 1, 0, 0, 32'h0);
        run(0, 32'h80000008, 32'h0, 0, 0, 1, 0, 0, 32'h0);
        // backpressure store
        run(0, 32'h80000020, 32'h12345678, 0, 1, 1, 5, 1, 32'hFFFFFFFF);

        // timeout in WAIT, then a stale response in IDLE
        run(1, 32'h80000030, 32'h0, 1, 0, 1, 0, 100, 32'h0);
        mem_rsp_valid = 1'b1; mem_req_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        chk("stale_ignored", o_resp_valid, 0);
        chk("stale_idle", o_req_ready, 1);
        @(negedge clk);
        chk("stale_ignored2", o_resp_valid, 0);
        // timeout in REQ; response exactly on the limit cycle
        run(1, 32'h80000034, 32'h0, 1, 0, 1, 100, 0, 32'h0);
        run(1, 32'h80000038, 32'h0, 1, 0, 1, 0, 2, 32'h600DF00D);

        // randomized accesses
        for (int i = 0; i < 40; i++) begin
            bit s;
            s = (i % 4 == 3);
            run(s, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, s ? 2 : 4)), int'($urandom_range(0, s ? 2 : 4)), $urandom);
        end

        // reset mid-WAIT
        @(negedge clk);
        sel = 1'b0;
        addr = 32'h80000040; read = 1'b1; write = 1'b0; word = 1'b1; req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("in_wait", o_req_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", o_mem_req_valid, 0);
        chk("arst_resp_valid", o_resp_valid, 0);
        chk("arst_mem_addr", o_mem_addr, 0);
        chk("arst_mem_wen", o_mem_wen, 0);
        chk("arst_resp_err", o_resp_err, 0);
        mem_rsp_valid = 1'b1; mem_rdata = 32'h11111111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_no_resp", o_resp_valid, 0);
        end
        mem_rsp_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_no_resp", o_resp_valid, 0);
        run(0, 32'h80000044, 32'h0, 1, 0, 1, 0, 0, 32'h0BADCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
